png_chunk_gen: RTL and testbench

- Frames one PNG chunk from a 32-bit payload word stream. Output order: length word, type word, payload words, CRC word.
- Sits directly upstream of crc32. Drives crc32's start/val/dat/lst inputs with the type and payload words, then consumes crc32's done/dat result as the chunk trailer.
- Output feeds the PNG byte/word writer through a valid/ready stream.

---
 rtl/png_pkg.sv | 27 ++
 rtl/png_out_reg.sv | 30 +++
 rtl/png_chunk_gen.sv | 180 ++++++++++++++++++
 tb/tb_png_chunk_gen.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/png_pkg.sv
// Shared definitions for the PNG encoder blocks: FSM state encoding,
// CRC word width and the standard chunk type codes (big-endian ASCII).
package png_pkg;

  localparam int CRC_WD = 32;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_LEN_ENC  = 3'd1;
  localparam logic [2:0] ST_TYPE_ENC = 3'd2;
  localparam logic [2:0] ST_DATA_ENC = 3'd3;
  localparam logic [2:0] ST_WCRC_ENC = 3'd4;
  localparam logic [2:0] ST_CRC_ENC  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_LEN  = ST_LEN_ENC,
    ST_TYPE = ST_TYPE_ENC,
    ST_DATA = ST_DATA_ENC,
    ST_WCRC = ST_WCRC_ENC,
    ST_CRC  = ST_CRC_ENC
  } png_state_e;

  localparam logic [31:0] TYPE_IHDR = 32'h49484452;
  localparam logic [31:0] TYPE_IDAT = 32'h49444154;
  localparam logic [31:0] TYPE_IEND = 32'h49454E44;

endpackage

// File: rtl/png_out_reg.sv
// Single-entry valid/ready output register. Accepts a new word whenever it
// is empty or its current word is being taken this cycle; otherwise the
// held word and valid stay stable.
module png_out_reg #(
  parameter int DATA_WD = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ld,
  input  logic [DATA_WD-1:0] ld_dat,
  output logic               free,
  output logic               val,
  output logic [DATA_WD-1:0] dat,
  input  logic               rdy
);

  assign free = !val || rdy;

  // Capture a word when free; drop valid when the word leaves with nothing new.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val <= 1'b0;
      dat <= '0;
    end else if (free) begin
      val <= ld;
      if (ld) dat <= ld_dat;
    end
  end

endmodule

// File: rtl/png_chunk_gen.sv
// PNG chunk framer: emits length, type, payload words and the CRC word
// returned by an attached crc32 engine. Type and payload words are handed
// to crc32 exactly once, on the cycle they load the output register.
// Optional macro PNG_CHUNK_LEN_CHK_EN enables the sticky in_lst_i vs.
// byte-length consistency flag on err_o; without it err_o is tied low.
module png_chunk_gen
  import png_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int LEN_WD  = 31
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [LEN_WD-1:0]  len_i,
  input  logic [DATA_WD-1:0] type_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               in_val_i,
  input  logic [DATA_WD-1:0] in_dat_i,
  input  logic               in_lst_i,
  output logic               in_rdy_o,
  output logic               out_val_o,
  output logic [DATA_WD-1:0] out_dat_o,
  input  logic               out_rdy_i,
  output logic               crc_start_o,
  output logic               crc_val_o,
  output logic [DATA_WD-1:0] crc_dat_o,
  output logic               crc_lst_o,
  input  logic               crc_done_i,
  input  logic [DATA_WD-1:0] crc_dat_i,
  output logic               err_o
);

  localparam logic [LEN_WD-3:0] CNT_ONE = 1;

  png_state_e         state_q;
  logic [LEN_WD-3:0]  cnt_q;       // payload words still to come
  logic [DATA_WD-1:0] type_q;
  logic [CRC_WD-1:0]  crc_hold_q;  // CRC parked here until the output register frees
  logic               crc_sent_q;  // CRC word already sits in the output register
  logic               ld;
  logic [DATA_WD-1:0] ld_dat;
  logic               free;
  logic               start_acc;
  logic [DATA_WD-1:0] len_word;

  // Byte length rounded down to whole words; the two LSBs of len_i never count.
  logic [1:0] unused_len_lsb;
  assign unused_len_lsb = len_i[1:0];

  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign len_word  = {{(DATA_WD-LEN_WD){1'b0}}, cnt_q, 2'b00};

  png_out_reg #(.DATA_WD(DATA_WD)) u_out_reg (
    .clk    (clk),
    .rstn   (rstn),
    .ld     (ld),
    .ld_dat (ld_dat),
    .free   (free),
    .val    (out_val_o),
    .dat    (out_dat_o),
    .rdy    (out_rdy_i)
  );

  // Per-state output-register load and the matching crc32 strobe.
  always_comb begin
    ld        = 1'b0;
    ld_dat    = '0;
    in_rdy_o  = 1'b0;
    crc_val_o = 1'b0;
    crc_dat_o = '0;
    crc_lst_o = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      ST_LEN: begin
        ld     = free;
        ld_dat = len_word;
      end
      ST_TYPE: begin
        ld        = free;
        ld_dat    = type_q;
        crc_val_o = free;
        crc_dat_o = free ? type_q : '0;
        crc_lst_o = free && (cnt_q == '0);
      end
      ST_DATA: begin
        in_rdy_o  = free;
        ld        = free && in_val_i;
        ld_dat    = in_dat_i;
        crc_val_o = ld;
        crc_dat_o = ld ? in_dat_i : '0;
        crc_lst_o = ld && (cnt_q == CNT_ONE);
      end
      ST_CRC: begin
        ld     = free && !crc_sent_q;
        ld_dat = crc_hold_q;
        done_o = crc_sent_q && out_val_o && out_rdy_i;
      end
      default: ;
    endcase
  end

  // Chunk sequencing: latch the request, walk the words, collect the CRC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      crc_hold_q  <= '0;
      crc_sent_q  <= 1'b0;
      busy_o      <= 1'b0;
      crc_start_o <= 1'b0;
    end else begin
      crc_start_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q       <= len_i[LEN_WD-1:2];
            type_q      <= type_i;
            busy_o      <= 1'b1;
            crc_start_o <= 1'b1;
            state_q     <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (free) state_q <= ST_TYPE;
        end
        ST_TYPE: begin
          if (free) state_q <= (cnt_q == '0) ? ST_WCRC : ST_DATA;
        end
        ST_DATA: begin
          if (ld) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_q <= ST_WCRC;
          end
        end
        ST_WCRC: begin
          if (crc_done_i) begin
            crc_hold_q <= crc_dat_i;
            state_q    <= ST_CRC;
          end
        end
        ST_CRC: begin
          if (!crc_sent_q) begin
            if (free) crc_sent_q <= 1'b1;
          end else if (out_val_o && out_rdy_i) begin
            crc_sent_q <= 1'b0;
            busy_o     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PNG_CHUNK_LEN_CHK_EN
  logic err_q;
  assign err_o = err_q;

  // Sticky flag: in_lst_i must mark exactly the final counted payload word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_DATA) && ld && (in_lst_i != (cnt_q == CNT_ONE))) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_lst;
  logic unused_start_acc;
  assign unused_lst       = in_lst_i;
  assign unused_start_acc = start_acc;
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_png_chunk_gen.sv
// Bench for png_chunk_gen: directed chunks against a queue-based model of
// the chunk byte stream, with a behavioural crc32 stand-in on the crc port.
`timescale 1ns/1ps
module tb_png_chunk_gen;
  import png_pkg::*;

`ifdef PNG_CHUNK_LEN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start_i = 1'b0;
  logic [30:0] len_i = '0;
  logic [31:0] type_i = '0;
  logic        busy_o, done_o;
  logic        in_val_i = 1'b0;
  logic [31:0] in_dat_i = '0;
  logic        in_lst_i = 1'b0;
  logic        in_rdy_o;
  logic        out_val_o;
  logic [31:0] out_dat_o;
  logic        out_rdy_i = 1'b0;
  logic        crc_start_o, crc_val_o, crc_lst_o;
  logic [31:0] crc_dat_o;
  logic        crc_done_i = 1'b0;
  logic [31:0] crc_dat_i = '0;
  logic        err_o;

  always #5 clk = ~clk;

  png_chunk_gen #(.DATA_WD(32), .LEN_WD(31)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .type_i(type_i),
    .busy_o(busy_o), .done_o(done_o),
    .in_val_i(in_val_i), .in_dat_i(in_dat_i), .in_lst_i(in_lst_i), .in_rdy_o(in_rdy_o),
    .out_val_o(out_val_o), .out_dat_o(out_dat_o), .out_rdy_i(out_rdy_i),
    .crc_start_o(crc_start_o), .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o),
    .crc_lst_o(crc_lst_o), .crc_done_i(crc_done_i), .crc_dat_i(crc_dat_i),
    .err_o(err_o)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_out[$];
  logic [31:0] exp_crc[$];
  logic [31:0] seen[$];
  logic [31:0] wq[$];
  logic        err_exp = 1'b0;
  int          rdy_mode = 0;     // 0: ready high, 1: toggle, 2: ready low
  logic        stub_force = 1'b0;
  logic [31:0] stub_val = '0;
  int          stub_delay = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reflected CRC-32 (zlib), message bytes taken MSB-first from each word.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ {24'd0, w[8*b +: 8]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Downstream ready pattern, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1: out_rdy_i = ~out_rdy_i;
        2: out_rdy_i = 1'b0;
        default: out_rdy_i = 1'b1;
      endcase
    end
  end

  // crc32 stand-in: accumulates the words it is handed, answers after stub_delay cycles.
  initial begin : crc_stub
    logic [31:0] acc;
    logic [31:0] pval;
    int          pend;
    acc = '1; pval = '0; pend = 0;
    forever begin
      @(negedge clk);
      crc_done_i = 1'b0;
      if (!rstn) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            crc_done_i = 1'b1;
            crc_dat_i  = pval;
          end
        end
        if (crc_start_o) acc = '1;
        if (crc_val_o) begin
          acc = crc_upd(acc, crc_dat_o);
          if (crc_lst_o) begin
            pend = stub_delay;
            pval = stub_force ? stub_val : ~acc;
          end
        end
      end
    end
  end

  // Compare process: every mid-cycle, check the stream, crc port, done and err.
  initial begin : monitor
    logic        hs;
    logic        prev_stall;
    logic [31:0] prev_dat;
    logic [31:0] w;
    prev_stall = 1'b0; prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_val", {31'd0, out_val_o}, 32'd1);
          check("stall_dat", out_dat_o, prev_dat);
        end
        hs = out_val_o && out_rdy_i;
        check("done", {31'd0, done_o}, {31'd0, hs && (exp_out.size() == 1)});
        if (hs) begin
          seen.push_back(out_dat_o);
          if (exp_out.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_out: got %08h expected no word", out_dat_o);
          end else begin
            w = exp_out.pop_front();
            check("out_dat", out_dat_o, w);
          end
        end
        if (crc_val_o) begin
          if (exp_crc.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_crc: got %08h expected no crc word", crc_dat_o);
          end else begin
            w = exp_crc.pop_front();
            check("crc_dat", crc_dat_o, w);
            check("crc_lst", {31'd0, crc_lst_o}, {31'd0, exp_crc.size() == 0});
          end
        end
        check("err", {31'd0, err_o}, {31'd0, err_exp});
        prev_stall = out_val_o && !out_rdy_i;
        prev_dat   = out_dat_o;
      end
    end
  end

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #1;
    check({tag, "_rst_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_rst_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_rst_inrdy"}, {31'd0, in_rdy_o}, 32'd0);
    check({tag, "_rst_oval"}, {31'd0, out_val_o}, 32'd0);
    check({tag, "_rst_odat"}, out_dat_o, 32'd0);
    check({tag, "_rst_cstart"}, {31'd0, crc_start_o}, 32'd0);
    check({tag, "_rst_cval"}, {31'd0, crc_val_o}, 32'd0);
    check({tag, "_rst_cdat"}, crc_dat_o, 32'd0);
    check({tag, "_rst_clst"}, {31'd0, crc_lst_o}, 32'd0);
    check({tag, "_rst_err"}, {31'd0, err_o}, 32'd0);
    exp_out.delete(); exp_crc.delete();
    err_exp = 1'b0; in_val_i = 1'b0; in_lst_i = 1'b0; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One chunk end to end. abort_after >= 0 stops feeding after that many words.
  task automatic run_chunk(input string tag, input logic [31:0] typ, input logic [30:0] len,
                           input logic [31:0] words[$], input logic [31:0] lst_mask,
                           input bit hold, input int abort_after);
    logic [31:0] c;
    int          n;
    int          t;
    bit          got;
    n = int'(len >> 2);
    c = 32'hFFFFFFFF;
    c = crc_upd(c, typ);
    for (int i = 0; i < n; i++) c = crc_upd(c, words[i]);
    check({tag, "_q_out_empty"}, exp_out.size(), 32'd0);
    check({tag, "_q_crc_empty"}, exp_crc.size(), 32'd0);
    exp_out.push_back({1'b0, len[30:2], 2'b00});
    exp_out.push_back(typ);
    exp_crc.push_back(typ);
    for (int i = 0; i < n; i++) begin
      exp_out.push_back(words[i]);
      exp_crc.push_back(words[i]);
    end
    exp_out.push_back(stub_force ? stub_val : ~c);
    seen.delete();

    @(posedge clk); #1;
    start_i = 1'b1; len_i = len; type_i = typ;
    #1 check({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; err_exp = 1'b0;
    len_i = 31'h7FFFFFFF; type_i = 32'hFFFFFFFF;
    @(negedge clk);
    check({tag, "_t1_busy"}, {31'd0, busy_o}, 32'd1);
    check({tag, "_t1_oval"}, {31'd0, out_val_o}, 32'd0);
    check({tag, "_t1_cstart"}, {31'd0, crc_start_o}, 32'd1);
    @(negedge clk);
    check({tag, "_t2_oval"}, {31'd0, out_val_o}, 32'd1);
    check({tag, "_t2_cstart"}, {31'd0, crc_start_o}, 32'd0);

    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (abort_after >= 0 && i >= abort_after) break;
      in_val_i = 1'b1; in_dat_i = words[i]; in_lst_i = lst_mask[i];
      got = 1'b0; t = 0;
      while (!got && t < 100) begin
        @(negedge clk);
        got = in_rdy_o;
        @(posedge clk); #1;
        t++;
      end
      if (!got) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_feed_timeout: word %0d never accepted, expected acceptance", tag, i);
      end else if (CHK_EN && (lst_mask[i] != (i == n - 1))) begin
        err_exp = 1'b1;
      end
      if (rdy_mode == 0 && i > 0) check({tag, "_thruput"}, t, 32'd1);
    end
    in_val_i = 1'b0; in_lst_i = 1'b0;
    if (abort_after >= 0) return;

    if (hold) begin
      rdy_mode = 2;
      repeat (10) @(negedge clk);
      check({tag, "_hold_oval"}, {31'd0, out_val_o}, 32'd1);
      check({tag, "_hold_odat"}, out_dat_o, words[n-1]);
      @(posedge clk); #1;
      rdy_mode = 0;
    end

    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    #1;
    check({tag, "_nwords"}, seen.size(), n + 3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset("por");

    // IEND, empty payload
    rdy_mode = 0;
    wq.delete();
    run_chunk("iend", TYPE_IEND, 31'd0, wq, 32'd0, 1'b0, -1);
    check("iend_w0", seen[0], 32'h00000000);
    check("iend_w1", seen[1], 32'h49454E44);
    check("iend_w2", seen[2], 32'hAE426082);

    // IDAT, two words, free-running ready (starts the cycle after done)
    wq.delete(); wq.push_back(32'h04090409); wq.push_back(32'h00000000);
    run_chunk("idat", TYPE_IDAT, 31'd8, wq, 32'h2, 1'b0, -1);
    check("idat_w0", seen[0], 32'h00000008);
    check("idat_w2", seen[2], 32'h04090409);
    check("idat_w3", seen[3], 32'h00000000);

    // Same chunk with ready toggling every cycle
    rdy_mode = 1;
    run_chunk("idat_tgl", TYPE_IDAT, 31'd8, wq, 32'h2, 1'b0, -1);
    rdy_mode = 0;

    // IHDR with 13 bytes: low length bits dropped, 3 words framed
    wq.delete(); wq.push_back(32'h00000010); wq.push_back(32'h00000020); wq.push_back(32'h08020000);
    run_chunk("ihdr13", TYPE_IHDR, 31'd13, wq, 32'h4, 1'b0, -1);
    check("ihdr13_len", seen[0], 32'h0000000C);

    // Late crc32 answer while downstream is stalled
    stub_force = 1'b1; stub_val = 32'h12345678; stub_delay = 5;
    wq.delete(); wq.push_back(32'hDEADBEEF);
    run_chunk("stub", TYPE_IDAT, 31'd4, wq, 32'h1, 1'b1, -1);
    check("stub_crc", seen[seen.size()-1], 32'h12345678);
    stub_force = 1'b0; stub_delay = 1;

    // Reset in the middle of a payload, then a clean IEND
    wq.delete();
    wq.push_back(32'h11111111); wq.push_back(32'h22222222);
    wq.push_back(32'h33333333); wq.push_back(32'h44444444);
    run_chunk("abort", TYPE_IDAT, 31'd16, wq, 32'h8, 1'b0, 1);
    do_reset("mid");
    wq.delete();
    run_chunk("iend2", TYPE_IEND, 31'd0, wq, 32'd0, 1'b0, -1);
    check("iend2_w2", seen[2], 32'hAE426082);

    // in_lst_i on the first of two words: framing intact, err_o per build
    wq.delete(); wq.push_back(32'hCAFEF00D); wq.push_back(32'h0BADC0DE);
    run_chunk("lsterr", TYPE_IDAT, 31'd8, wq, 32'h3, 1'b0, -1);
    check("lsterr_flag", {31'd0, err_o}, {31'd0, CHK_EN});
    wq.delete();
    run_chunk("iend3", TYPE_IEND, 31'd0, wq, 32'd0, 1'b0, -1);
    check("iend3_errclr", {31'd0, err_o}, 32'd0);

    repeat (4) @(negedge clk);
    check("end_q_out", exp_out.size(), 32'd0);
    check("end_q_crc", exp_crc.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
